fp_fxp_mul_seq: RTL and testbench
=================================

FP_FXP_MUL_SEQ -- requirements
Module: fp_fxp_mul_seq

Interface
REQ-001 The block SHALL have parameter FXP_WIDTH, default 4, meaning the width of the two's-complement fixed-point operand a, legal range 2..16.
REQ-002 The block SHALL have parameter FP_WIDTH, default 32, meaning the floating-point word width.
REQ-003 The block SHALL have parameter FP_FRAC_WIDTH, default 23, meaning the mantissa width; FP_EXP_WIDTH SHALL equal FP_WIDTH-FP_FRAC_WIDTH-1.
REQ-004 The block SHALL have parameter SKIP_ZERO, default 1; when 1, zero bits of |a| are skipped, and when 0, every bit position is issued.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the sequencer accepts a pair.
REQ-009 The block SHALL have port in_a, input, FXP_WIDTH bits: the fixed-point operand, two's complement.
REQ-010 The block SHALL have port in_b, input, FP_WIDTH bits: the floating-point operand {sign, exp, frac}.
REQ-011 The block SHALL have port in_b_zero, input, 1 bit: in_b is zero.
REQ-012 The block SHALL have port pp_valid, output, 1 bit: a partial product is presented.
REQ-013 The block SHALL have port pp_ready, input, 1 bit: the consumer takes the partial product.
REQ-014 The block SHALL have port pp_result, output, FP_WIDTH bits: the partial product b*bit*2^exp, with the sign applied.
REQ-015 The block SHALL have port pp_exp, output, 4 bits: the bit index of the current partial product.
REQ-016 The block SHALL have port pp_last, output, 1 bit: the final partial product of the current pair.
REQ-017 The block SHALL have port busy, output, 1 bit: the block is in state RUN.

Function
REQ-018 The block SHALL implement the states IDLE and RUN; in_ready SHALL equal (state==IDLE), and busy SHALL equal (state==RUN).
REQ-019 On in_valid&&in_ready, the block SHALL register in_b and in_b_zero, sign = in_a[MSB], and mag = |in_a| as FXP_WIDTH-bit unsigned (most-negative input gives mag = 2^(FXP_WIDTH-1)), and SHALL go to RUN.
REQ-020 The first pp_valid SHALL assert the cycle after acceptance, giving a latency of 1 cycle.
REQ-021 With SKIP_ZERO=1, the block SHALL issue one partial product per set bit of mag in ascending index order.
REQ-022 With SKIP_ZERO=0, the block SHALL issue FXP_WIDTH partial products with indices 0..FXP_WIDTH-1, with a_bit = mag[index].
REQ-023 If mag==0 or b_zero is set, the block SHALL issue exactly one partial product with index 0 and a_bit 0, with pp_last=1.
REQ-024 pp_last SHALL assert on the highest set bit when SKIP_ZERO=1, and on index FXP_WIDTH-1 when SKIP_ZERO=0.
REQ-025 pp_result SHALL be produced combinationally by the multiplier from {a_bit, sign, pp_exp, registered b, b_zero}.
REQ-026 While pp_valid&&!pp_ready, pp_result, pp_exp and pp_last SHALL hold stable.
REQ-027 Advancing to the next index SHALL occur only on pp_valid&&pp_ready.
REQ-028 On the pp_last handshake, the block SHALL return to IDLE, with pp_valid low the next cycle; in_ready SHALL rise in that next cycle, leaving one bubble between pairs.
REQ-029 The next-set-bit search SHALL be a priority encoder over mag masked above the current index, using no extra cycles.
REQ-030 Exponent overflow from b_exp+index SHALL wrap modulo 2^FP_EXP_WIDTH, matching the multiplier; no saturation is performed.

Reset
REQ-031 While reset is high at a clk edge, the block SHALL enter IDLE and clear the registered operands.
REQ-032 After reset, the outputs SHALL be: pp_valid=0, pp_last=0, pp_exp=0, busy=0, and in_ready=1 from the first cycle after reset deasserts.
REQ-033 A reset in RUN SHALL abandon the current pair, with no further partial products issued.

Structure
REQ-034 The state encoding (IDLE/RUN) and the 4-bit exponent-index width constant SHALL reside in the shared package fp_fxp_pkg.
REQ-035 The block SHALL instantiate exactly one sub-module, the existing fp_fxp_mul datapath; the sequencer logic SHALL remain local.

Verification
REQ-036 Scenario: a=5, b=0x3F800000, SKIP_ZERO=1, pp_ready=1 -> two partial products: (exp 0, 0x3F800000, last 0), then (exp 2, 0x40800000, last 1).
REQ-037 Scenario: a=-3 (4'b1101), b=0x3F800000 -> (exp 0, 0xBF800000), then (exp 1, 0xC0000000, last 1).
REQ-038 Scenario: a=-8, b=0x3F800000 -> a single partial product (exp 3, 0xC1000000, last 1); a=0 or b_zero=1 -> a single partial product 0x00000000 with last 1.
REQ-039 Scenario: SKIP_ZERO=0, a=5 -> four partial products with exp 0..3, results 0x3F800000, 0, 0x40800000, 0, and last on exp 3.
REQ-040 Scenario: pp_ready held low for 3 cycles mid-sequence -> outputs stable, no index skipped, order preserved.
REQ-041 Scenario: reset pulsed during RUN -> the next cycle shows pp_valid=0, busy=0, in_ready=1, and a new pair is processed correctly.

Source files
------------

// File: rtl/fp_fxp_pkg.sv
// Shared definitions for the fixed-point x floating-point sequential multiplier.
// Holds the sequencer state encoding and the width of the partial-product
// bit index (pp_exp), which is fixed at 4 bits so it can address up to
// 16 operand bits.
package fp_fxp_pkg;

   localparam int EXP_IDX_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage : fp_fxp_pkg

// File: rtl/fp_fxp_mul_seq_if.sv
// Handshake bundle for fp_fxp_mul_seq.
// Operand channel : in_valid/in_ready, in_a (two's complement), in_b (FP word),
//                   in_b_zero.
// Result channel  : pp_valid/pp_ready, pp_result, pp_exp (bit index), pp_last.
// Status          : busy.
// The slave modport is the sequencer side; the master modport is the side that
// offers operands and consumes partial products.
interface fp_fxp_mul_seq_if #(
   parameter int FXP_WIDTH = 4,
   parameter int FP_WIDTH  = 32
);
   import fp_fxp_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [FXP_WIDTH-1:0] in_a;
   logic [FP_WIDTH-1:0]  in_b;
   logic                 in_b_zero;
   logic                 pp_valid;
   logic                 pp_ready;
   logic [FP_WIDTH-1:0]  pp_result;
   logic [EXP_IDX_W-1:0] pp_exp;
   logic                 pp_last;
   logic                 busy;

   modport master (
      output in_valid, in_a, in_b, in_b_zero, pp_ready,
      input  in_ready, pp_valid, pp_result, pp_exp, pp_last, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_b_zero, pp_ready,
      output in_ready, pp_valid, pp_result, pp_exp, pp_last, busy
   );

endinterface : fp_fxp_mul_seq_if

// File: rtl/fp_fxp_mul.sv
// Single-bit partial-product datapath: result = b * a_bit * 2^exp_idx with
// the operand sign folded into the FP sign bit.
// Ports:
//   a_bit   - current magnitude bit of the fixed-point operand
//   sign    - sign of the fixed-point operand (1 = negative)
//   exp_idx - bit index, added to the FP exponent
//   b       - FP operand {sign, exp, frac}
//   b_zero  - b is zero
//   result  - partial product; all zeros when a_bit=0 or b_zero=1
// The exponent sum wraps modulo 2^FP_EXP_WIDTH; no saturation is applied.
module fp_fxp_mul
   import fp_fxp_pkg::*;
#(
   parameter int FP_WIDTH      = 32,
   parameter int FP_FRAC_WIDTH = 23
) (
   input  logic                 a_bit,
   input  logic                 sign,
   input  logic [EXP_IDX_W-1:0] exp_idx,
   input  logic [FP_WIDTH-1:0]  b,
   input  logic                 b_zero,
   output logic [FP_WIDTH-1:0]  result
);

   localparam int FP_EXP_WIDTH = FP_WIDTH - FP_FRAC_WIDTH - 1;

   logic [FP_EXP_WIDTH-1:0] b_exp;
   logic [FP_EXP_WIDTH-1:0] exp_sum;

   assign b_exp   = b[FP_WIDTH-2 -: FP_EXP_WIDTH];
   assign exp_sum = b_exp + FP_EXP_WIDTH'(exp_idx);

   always_comb begin
      if (!a_bit || b_zero) begin
         result = '0;
      end else begin
         result = {b[FP_WIDTH-1] ^ sign, exp_sum, b[FP_FRAC_WIDTH-1:0]};
      end
   end

endmodule : fp_fxp_mul

// File: rtl/fp_fxp_mul_seq.sv
// Sequencer that breaks a fixed-point x floating-point product into one
// partial product per bit of |a|, presented on a valid/ready channel.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - slave side of fp_fxp_mul_seq_if (operand in, partial products out,
//           busy status)
// SKIP_ZERO=1 issues only the set bits of |a| (ascending); SKIP_ZERO=0 issues
// every index 0..FXP_WIDTH-1. A zero magnitude or zero b yields one zero
// partial product at index 0 flagged last.
module fp_fxp_mul_seq
   import fp_fxp_pkg::*;
#(
   parameter int FXP_WIDTH     = 4,
   parameter int FP_WIDTH      = 32,
   parameter int FP_FRAC_WIDTH = 23,
   parameter bit SKIP_ZERO     = 1'b1
) (
   input logic              clk,
   input logic              reset,
   fp_fxp_mul_seq_if.slave  bus
);

   state_t state, state_next;

   logic [FP_WIDTH-1:0]  b_reg;
   logic                 b_zero_reg;
   logic                 sign_reg;
   logic [FXP_WIDTH-1:0] mag_reg;
   logic [EXP_IDX_W-1:0] idx_reg;   // lowest index still to be issued

   logic                 accept;
   logic                 pp_fire;
   logic [FXP_WIDTH-1:0] in_mag;

   // Next-set-bit search
   logic [FXP_WIDTH-1:0] masked;
   logic [FXP_WIDTH-1:0] lowest;
   logic [FXP_WIDTH-1:0] mag_shift;
   logic [EXP_IDX_W-1:0] hit_idx;
   logic                 more_bits;
   logic                 empty;

   // Current partial product selection
   logic [EXP_IDX_W-1:0] cur_idx;
   logic                 cur_bit;
   logic                 cur_last;

   logic                 a_bit;
   logic [EXP_IDX_W-1:0] pp_exp;
   logic                 pp_last;
   logic [FP_WIDTH-1:0]  pp_result;

   assign accept  = bus.in_valid && (state == ST_IDLE);
   assign pp_fire = (state == ST_RUN) && bus.pp_ready;

   // Two's-complement magnitude; the most negative value maps to 2^(W-1),
   // which still fits as an unsigned W-bit number.
   assign in_mag = bus.in_a[FXP_WIDTH-1] ? (~bus.in_a) + FXP_WIDTH'(1) : bus.in_a;

   // Isolate the lowest set bit at or above idx_reg; any set bit left over
   // means the current one is not the last.
   assign masked    = mag_reg & ({FXP_WIDTH{1'b1}} << idx_reg);
   assign lowest    = masked & ((~masked) + FXP_WIDTH'(1));
   assign more_bits = |(masked & ~lowest);
   assign mag_shift = mag_reg >> idx_reg;
   assign empty     = (mag_reg == '0) || b_zero_reg;

   // NOTE: every always_comb output gets a default before any conditional
   // assignment, so no path can leave it unassigned and infer a latch.
   always_comb begin
      hit_idx = '0;
      for (int i = FXP_WIDTH - 1; i >= 0; i--) begin
         if (lowest[i]) hit_idx = EXP_IDX_W'(i);
      end
   end

   always_comb begin
      cur_idx  = '0;
      cur_bit  = 1'b0;
      cur_last = 1'b1;
      if (!empty) begin
         if (SKIP_ZERO) begin
            cur_idx  = hit_idx;
            cur_bit  = 1'b1;
            cur_last = !more_bits;
         end else begin
            cur_idx  = idx_reg;
            cur_bit  = mag_shift[0];
            cur_last = (idx_reg == EXP_IDX_W'(FXP_WIDTH - 1));
         end
      end
   end

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (bus.in_valid)        state_next = ST_RUN;
         ST_RUN:  if (pp_fire && cur_last) state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.in_ready = 1'b0;
      bus.busy     = 1'b0;
      bus.pp_valid = 1'b0;
      pp_exp       = '0;
      pp_last      = 1'b0;
      a_bit        = 1'b0;
      case (state)
         ST_IDLE: bus.in_ready = 1'b1;
         ST_RUN: begin
            bus.busy     = 1'b1;
            bus.pp_valid = 1'b1;
            pp_exp       = cur_idx;
            pp_last      = cur_last;
            a_bit        = cur_bit;
         end
         default: ;
      endcase
   end

   // Operand registers and index pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         b_reg      <= '0;
         b_zero_reg <= 1'b0;
         sign_reg   <= 1'b0;
         mag_reg    <= '0;
         idx_reg    <= '0;
      end else if (accept) begin
         b_reg      <= bus.in_b;
         b_zero_reg <= bus.in_b_zero;
         sign_reg   <= bus.in_a[FXP_WIDTH-1];
         mag_reg    <= in_mag;
         idx_reg    <= '0;
      end else if (pp_fire) begin
         idx_reg    <= cur_idx + EXP_IDX_W'(1);
      end
   end

   fp_fxp_mul #(
      .FP_WIDTH      (FP_WIDTH),
      .FP_FRAC_WIDTH (FP_FRAC_WIDTH)
   ) u_mul (
      .a_bit   (a_bit),
      .sign    (sign_reg),
      .exp_idx (pp_exp),
      .b       (b_reg),
      .b_zero  (b_zero_reg),
      .result  (pp_result)
   );

   assign bus.pp_result = pp_result;
   assign bus.pp_exp    = pp_exp;
   assign bus.pp_last   = pp_last;

endmodule : fp_fxp_mul_seq

// File: tb/tb_fp_fxp_mul_seq.sv
// Directed bench for fp_fxp_mul_seq: one instance with SKIP_ZERO=1 and one
// with SKIP_ZERO=0, driven from tables of hand-computed partial products,
// plus sequences for back-pressure and reset during RUN.
module tb_fp_fxp_mul_seq;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   fp_fxp_mul_seq_if #(.FXP_WIDTH(4), .FP_WIDTH(32)) if0 ();
   fp_fxp_mul_seq_if #(.FXP_WIDTH(4), .FP_WIDTH(32)) if1 ();

   fp_fxp_mul_seq #(
      .FXP_WIDTH(4), .FP_WIDTH(32), .FP_FRAC_WIDTH(23), .SKIP_ZERO(1'b1)
   ) u_skip (
      .clk   (clk),
      .reset (reset),
      .bus   (if0.slave)
   );

   fp_fxp_mul_seq #(
      .FXP_WIDTH(4), .FP_WIDTH(32), .FP_FRAC_WIDTH(23), .SKIP_ZERO(1'b0)
   ) u_full (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] b;
      logic        bz;
      int          n;
      logic [3:0]  ex  [4];
      logic [31:0] res [4];
   } vec_t;

   vec_t skip_vecs [9];
   vec_t full_vecs [3];

   function automatic vec_t mk(input logic [3:0] a, input logic [31:0] b,
                               input logic bz, input int n,
                               input logic [3:0] e0, input logic [31:0] r0,
                               input logic [3:0] e1, input logic [31:0] r1,
                               input logic [3:0] e2, input logic [31:0] r2,
                               input logic [3:0] e3, input logic [31:0] r3);
      vec_t v;
      v.a = a; v.b = b; v.bz = bz; v.n = n;
      v.ex[0] = e0; v.res[0] = r0;
      v.ex[1] = e1; v.res[1] = r1;
      v.ex[2] = e2; v.res[2] = r2;
      v.ex[3] = e3; v.res[3] = r3;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic [3:0] a,
                        input logic [31:0] b, input logic bz);
      if (sel) begin
         if1.in_valid = v; if1.in_a = a; if1.in_b = b; if1.in_b_zero = bz;
      end else begin
         if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.in_b_zero = bz;
      end
   endtask

   task automatic set_ready(input bit sel, input logic r);
      if (sel) if1.pp_ready = r;
      else     if0.pp_ready = r;
   endtask

   task automatic sample(input bit sel, output logic pv, output logic pl,
                         output logic ir, output logic bsy,
                         output logic [3:0] pe, output logic [31:0] pr);
      if (sel) begin
         pv = if1.pp_valid; pl = if1.pp_last; ir = if1.in_ready;
         bsy = if1.busy; pe = if1.pp_exp; pr = if1.pp_result;
      end else begin
         pv = if0.pp_valid; pl = if0.pp_last; ir = if0.in_ready;
         bsy = if0.busy; pe = if0.pp_exp; pr = if0.pp_result;
      end
   endtask

   // Checks one presented partial product against the expectation.
   task automatic check_pp(input bit sel, input string tag, input logic [3:0] ex,
                           input logic [31:0] res, input logic last);
      logic pv, pl, ir, bsy;
      logic [3:0] pe;
      logic [31:0] pr;
      sample(sel, pv, pl, ir, bsy, pe, pr);
      check({tag, " pp_valid"},  32'(pv), 32'(1));
      check({tag, " pp_exp"},    32'(pe), 32'(ex));
      check({tag, " pp_result"}, pr, res);
      check({tag, " pp_last"},   32'(pl), 32'(last));
   endtask

   task automatic check_idle(input bit sel, input string tag);
      logic pv, pl, ir, bsy;
      logic [3:0] pe;
      logic [31:0] pr;
      sample(sel, pv, pl, ir, bsy, pe, pr);
      check({tag, " idle pp_valid"}, 32'(pv),  32'(0));
      check({tag, " idle busy"},     32'(bsy), 32'(0));
      check({tag, " idle in_ready"}, 32'(ir),  32'(1));
   endtask

   // Offers one pair with pp_ready held high and walks its partial products.
   task automatic run_vec(input bit sel, input vec_t v, input string tag);
      logic pv, pl, ir, bsy;
      logic [3:0] pe;
      logic [31:0] pr;
      @(negedge clk);
      sample(sel, pv, pl, ir, bsy, pe, pr);
      check({tag, " in_ready before offer"}, 32'(ir), 32'(1));
      drive(sel, 1'b1, v.a, v.b, v.bz);
      @(negedge clk);
      drive(sel, 1'b0, 4'h0, 32'h0, 1'b0);
      for (int k = 0; k < v.n; k++) begin
         check_pp(sel, $sformatf("%s pp%0d", tag, k), v.ex[k], v.res[k], k == v.n - 1);
         @(negedge clk);
      end
      check_idle(sel, tag);
   endtask

   initial begin
      logic pv, pl, ir, bsy;
      logic [3:0] pe;
      logic [31:0] pr;

      //                    a      b             bz n  e0 r0            e1 r1            e2 r2            e3 r3
      skip_vecs[0] = mk(4'd5, 32'h3F800000, 1'b0, 2, 0, 32'h3F800000, 2, 32'h40800000, 0, 0,            0, 0);
      skip_vecs[1] = mk(4'hD, 32'h3F800000, 1'b0, 2, 0, 32'hBF800000, 1, 32'hC0000000, 0, 0,            0, 0);
      skip_vecs[2] = mk(4'h8, 32'h3F800000, 1'b0, 1, 3, 32'hC1000000, 0, 0,            0, 0,            0, 0);
      skip_vecs[3] = mk(4'h0, 32'h3F800000, 1'b0, 1, 0, 32'h00000000, 0, 0,            0, 0,            0, 0);
      skip_vecs[4] = mk(4'd5, 32'h00000000, 1'b1, 1, 0, 32'h00000000, 0, 0,            0, 0,            0, 0);
      skip_vecs[5] = mk(4'd7, 32'hC0400000, 1'b0, 3, 0, 32'hC0400000, 1, 32'hC0C00000, 2, 32'hC1400000, 0, 0);
      skip_vecs[6] = mk(4'hF, 32'hC0400000, 1'b0, 1, 0, 32'h40400000, 0, 0,            0, 0,            0, 0);
      skip_vecs[7] = mk(4'd4, 32'h7F400000, 1'b0, 1, 2, 32'h00400000, 0, 0,            0, 0,            0, 0);
      skip_vecs[8] = mk(4'd6, 32'h3F800000, 1'b0, 2, 1, 32'h40000000, 2, 32'h40800000, 0, 0,            0, 0);

      full_vecs[0] = mk(4'd5, 32'h3F800000, 1'b0, 4, 0, 32'h3F800000, 1, 32'h0,        2, 32'h40800000, 3, 32'h0);
      full_vecs[1] = mk(4'h8, 32'h3F800000, 1'b0, 4, 0, 32'h0,        1, 32'h0,        2, 32'h0,        3, 32'hC1000000);
      full_vecs[2] = mk(4'd3, 32'h00000000, 1'b1, 1, 0, 32'h0,        0, 0,            0, 0,            0, 0);

      reset = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
      set_ready(1'b0, 1'b1);
      set_ready(1'b1, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      sample(1'b0, pv, pl, ir, bsy, pe, pr);
      check("reset pp_valid", 32'(pv),  32'(0));
      check("reset pp_last",  32'(pl),  32'(0));
      check("reset pp_exp",   32'(pe),  32'(0));
      check("reset busy",     32'(bsy), 32'(0));
      check("reset in_ready", 32'(ir),  32'(1));

      foreach (skip_vecs[i]) run_vec(1'b0, skip_vecs[i], $sformatf("skip%0d", i));
      foreach (full_vecs[i]) run_vec(1'b1, full_vecs[i], $sformatf("full%0d", i));

      // Back-pressure on the second of three partial products (a=7, b=1.0).
      @(negedge clk);
      drive(1'b0, 1'b1, 4'd7, 32'h3F800000, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      check_pp(1'b0, "stall pp0", 4'd0, 32'h3F800000, 1'b0);
      @(negedge clk);
      set_ready(1'b0, 1'b0);
      check_pp(1'b0, "stall pp1", 4'd1, 32'h40000000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_pp(1'b0, $sformatf("stall hold%0d", c), 4'd1, 32'h40000000, 1'b0);
      end
      set_ready(1'b0, 1'b1);
      @(negedge clk);
      check_pp(1'b0, "stall pp2", 4'd2, 32'h40800000, 1'b1);
      @(negedge clk);
      check_idle(1'b0, "stall");

      // Reset while a pair is in flight, then a fresh pair.
      set_ready(1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 4'd7, 32'h3F800000, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
      sample(1'b0, pv, pl, ir, bsy, pe, pr);
      check("run busy before reset", 32'(bsy), 32'(1));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle(1'b0, "mid reset");
      set_ready(1'b0, 1'b1);
      @(negedge clk);
      check_idle(1'b0, "post reset");
      run_vec(1'b0, skip_vecs[0], "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fp_fxp_mul_seq
